qspi_byte_assembler: RTL and testbench
======================================

Name: qspi_byte_assembler

Overview:
Sits directly downstream of the QSPI sampler. It takes the sampler's stream of 4-bit nibbles (one-cycle valid pulses) and pairs them into bytes. Bytes go into a small FIFO, and the consumer reads them through a valid/ready handshake. A transaction is bounded by a byte count latched at start, and completion is reported with a one-cycle done pulse once the FIFO has drained.

Parameters:
FIFO_DEPTH, 4, number of byte entries in the output FIFO; power of two, at least 2.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  reset; asynchronous, active-high; clears all state
start  input  1  one-cycle pulse; begins a transaction and latches byte_count; ignored while busy=1
abort  input  1  one-cycle pulse; cancels the transaction; has priority over every other input
byte_count  input  8  number of bytes expected in the transaction, sampled on start
nib_data  input  4  nibble from the sampler
nib_valid  input  1  nibble strobe from the sampler; one nibble per high cycle
out_data  output  8  FIFO head byte
out_valid  output  1  FIFO not empty
out_ready  input  1  consumer accepts the head byte when out_valid && out_ready
busy  output  1  high in ASSEMBLE and DRAIN states
done  output  1  one-cycle pulse when a transaction completes normally
overflow  output  1  sticky; a byte was dropped because the FIFO was full

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; FIFO emptied; half flag=0; remaining=0.
  - All outputs 0: out_data=0, out_valid=0, busy=0, done=0, overflow=0.
- States: IDLE, ASSEMBLE, DRAIN.
- IDLE:
  - nib_valid is ignored.
  - start with byte_count=0: done pulses the next cycle; state stays IDLE.
  - start with byte_count>0: remaining<=byte_count, half<=0, overflow<=0, state<=ASSEMBLE.
- ASSEMBLE, on each nib_valid:
  - half=0: store nibble as the high nibble; half<=1.
  - half=1: byte={high, nib_data} is pushed; half<=0; remaining<=remaining-1.
  - remaining==1 at that push: state<=DRAIN; later nib_valid pulses are ignored.
- Push acceptance:
  - A push is accepted if FIFO occupancy < FIFO_DEPTH.
  - It is also accepted if occupancy == FIFO_DEPTH and a pop happens in the same cycle.
  - Otherwise the byte is dropped, overflow<=1, and remaining still decrements. The flash stream cannot be stalled.
- Pop: when out_valid && out_ready, the head is removed. The next entry (if any) appears on out_data the following cycle.
- Occupancy counter: width clog2(FIFO_DEPTH)+1. Read and write pointers wrap modulo FIFO_DEPTH.
- DRAIN: when the FIFO is empty (including the cycle the last byte is popped), done pulses on the next cycle and state<=IDLE.
- Latency: second nibble of a byte arriving with an empty FIFO -> out_valid=1 and out_data valid on the next clock edge (1 cycle).
- abort (any state):
  - FIFO cleared, half<=0, state<=IDLE, no done pulse.
  - overflow is kept until the next start.
  - abort together with start: abort wins and the start is discarded.
- start while busy: ignored. No change to remaining, FIFO or overflow.
- A half-byte left at abort is discarded.
- out_data is 0 whenever the FIFO is empty.

Optional Feature:
- QSPI_ASM_LOW_FIRST_EN:
  - Defined: the first nibble of each pair is the low nibble, so byte={nib_data, first}.
  - Undefined (default): the first nibble is the high nibble, as above.
  - No other behaviour changes.

Test Plan:
- start, byte_count=2; nibbles A,B,C,D one cycle apart; out_ready=1 -> out_data 0xAB then 0xCD, each one cycle after its second nibble; done pulses once after the FIFO empties; busy then 0.
- start, byte_count=0 -> done pulses the next cycle; busy stays 0; no out_valid.
- FIFO_DEPTH=4, byte_count=6, out_ready=0, 12 nibbles 0..B -> FIFO holds 0x01,0x23,0x45,0x67; overflow=1; 0x89 and 0xAB are dropped; state reaches DRAIN; raising out_ready pops 4 bytes, then done.
- FIFO full with out_ready=1 in the same cycle a byte completes -> push accepted, no overflow; occupancy stays 4.
- abort after 3 nibbles of a byte_count=4 transaction -> out_valid=0 next cycle, busy=0, no done; a new start with byte_count=1 and nibbles 5,6 -> 0x56.
- rst asserted mid-ASSEMBLE with 2 bytes queued -> all outputs 0 immediately, without waiting for a clock; after release, nibbles are ignored until start.

Source files
------------

// File: rtl/qspi_byte_assembler.sv
// Pairs QSPI sampler nibbles into bytes, queues them in a small FIFO and signals transaction completion.
// Define QSPI_ASM_LOW_FIRST_EN so that the first nibble of each pair becomes the low nibble.
module qspi_byte_assembler #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] byte_count,
    input  logic [3:0] nib_data,
    input  logic       nib_valid,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       done,
    output logic       overflow
);

    localparam int unsigned AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic [1:0] {S_IDLE, S_ASSEMBLE, S_DRAIN} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_count;
    logic            r_half;
    logic [3:0]      r_first;
    logic [7:0]      r_remaining;
    logic            r_done;
    logic            r_overflow;

    logic            w_pop;
    logic            w_push_req;
    logic            w_push_ok;
    logic            w_drain_empty;
    logic            w_done_set;
    logic [7:0]      w_byte;

`ifdef QSPI_ASM_LOW_FIRST_EN
    assign w_byte = {nib_data, r_first};
`else
    assign w_byte = {r_first, nib_data};
`endif

    assign out_valid     = (r_count != '0);
    assign out_data      = out_valid ? r_mem[r_rptr] : '0;
    assign busy          = (r_state != S_IDLE);
    assign done          = r_done;
    assign overflow      = r_overflow;

    assign w_pop         = out_valid && out_ready;
    assign w_push_req    = (r_state == S_ASSEMBLE) && nib_valid && r_half && !abort;
    // A full FIFO still takes the byte when the head leaves in the same cycle.
    assign w_push_ok     = w_push_req && ((r_count < DEPTH_C) || w_pop);
    assign w_drain_empty = (r_count == '0) || ((r_count == CNT_ONE) && w_pop);

    always_comb begin
        w_state_nxt = r_state;
        w_done_set  = 1'b0;
        if (abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (byte_count == 8'd0) w_done_set  = 1'b1;
                        else                    w_state_nxt = S_ASSEMBLE;
                    end
                end
                S_ASSEMBLE: begin
                    if (w_push_req && (r_remaining == 8'd1)) w_state_nxt = S_DRAIN;
                end
                S_DRAIN: begin
                    if (w_drain_empty) begin
                        w_state_nxt = S_IDLE;
                        w_done_set  = 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_set;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wptr] <= w_byte;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_half      <= 1'b0;
            r_first     <= '0;
            r_remaining <= '0;
            r_overflow  <= 1'b0;
        end else if (abort) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_half  <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && start && (byte_count != 8'd0)) begin
                r_remaining <= byte_count;
                r_half      <= 1'b0;
                r_overflow  <= 1'b0;
            end
            if ((r_state == S_ASSEMBLE) && nib_valid) begin
                if (!r_half) begin
                    r_first <= nib_data;
                    r_half  <= 1'b1;
                end else begin
                    r_half      <= 1'b0;
                    r_remaining <= r_remaining - 8'd1;
                    if (!w_push_ok) r_overflow <= 1'b1;
                end
            end
            if (w_push_ok) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)     r_rptr <= r_rptr + PTR_ONE;
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_qspi_byte_assembler.sv
// Directed self-checking bench for qspi_byte_assembler (FIFO_DEPTH=4).
module tb_qspi_byte_assembler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] byte_count = '0;
    logic [3:0] nib_data = '0;
    logic       nib_valid = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       busy;
    logic       done;
    logic       overflow;

    int n_tests = 0;
    int n_fail  = 0;

    qspi_byte_assembler #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .byte_count(byte_count), .nib_data(nib_data), .nib_valid(nib_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected byte from the first and second nibble of a pair.
    function automatic logic [7:0] pair(input logic [3:0] first, input logic [3:0] second);
`ifdef QSPI_ASM_LOW_FIRST_EN
        return {second, first};
`else
        return {first, second};
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nib(input logic [3:0] n);
        nib_data  = n;
        nib_valid = 1'b1;
        tick();
        nib_valid = 1'b0;
    endtask

    task automatic go(input logic [7:0] bc);
        start      = 1'b1;
        byte_count = bc;
        tick();
        start      = 1'b0;
    endtask

    initial begin
        #3;
        check("rst_out_data", out_data, 0);
        check("rst_flags", {out_valid, busy, done, overflow}, 0);
        tick();
        rst = 1'b0;
        tick();

        // Two bytes, consumer always ready
        out_ready = 1'b1;
        go(8'd2);
        check("t1_busy", busy, 1);
        nib(4'hA);
        check("t1_no_valid_half", out_valid, 0);
        nib(4'hB);
        check("t1_byte0", {out_valid, out_data}, {1'b1, pair(4'hA, 4'hB)});
        nib(4'hC);
        check("t1_popped", out_valid, 0);
        nib(4'hD);
        check("t1_byte1", {out_valid, out_data}, {1'b1, pair(4'hC, 4'hD)});
        check("t1_no_done_yet", done, 0);
        tick();
        check("t1_done", {done, busy, out_valid}, 3'b100);
        tick();
        check("t1_done_single", done, 0);

        // Zero-length transaction
        go(8'd0);
        check("t2_done", {done, busy, out_valid}, 3'b100);
        tick();
        check("t2_done_single", {done, busy}, 2'b00);

        // Overflow: 6 bytes into a 4-deep FIFO with no consumer
        out_ready = 1'b0;
        go(8'd6);
        for (int i = 0; i < 12; i++) nib(4'(i));
        check("t3_overflow", overflow, 1);
        check("t3_in_drain", busy, 1);
        check("t3_head", {out_valid, out_data}, {1'b1, pair(4'h0, 4'h1)});
        nib(4'hF);
        check("t3_drain_ignores_nib", out_data, pair(4'h0, 4'h1));
        out_ready = 1'b1;
        tick();
        check("t3_pop1", out_data, pair(4'h2, 4'h3));
        tick();
        check("t3_pop2", out_data, pair(4'h4, 4'h5));
        tick();
        check("t3_pop3", {out_data, done}, {pair(4'h6, 4'h7), 1'b0});
        tick();
        check("t3_done", {done, busy, out_valid}, 3'b100);
        check("t3_overflow_sticky", overflow, 1);
        tick();

        // Full FIFO with simultaneous pop: push accepted
        out_ready = 1'b0;
        go(8'd5);
        check("t4_overflow_cleared", overflow, 0);
        for (int i = 1; i <= 9; i++) nib(4'(i));
        out_ready = 1'b1;
        nib(4'hA);
        check("t4_no_overflow", overflow, 0);
        check("t4_head", out_data, pair(4'h3, 4'h4));
        tick();
        check("t4_pop2", out_data, pair(4'h5, 4'h6));
        tick();
        check("t4_pop3", out_data, pair(4'h7, 4'h8));
        tick();
        check("t4_pop4", {out_valid, out_data}, {1'b1, pair(4'h9, 4'hA)});
        tick();
        check("t4_done", {done, out_valid, overflow}, 3'b100);
        tick();

        // Abort mid-byte, then a fresh one-byte transaction
        out_ready = 1'b0;
        go(8'd4);
        nib(4'h1);
        nib(4'h2);
        nib(4'h3);
        check("t5_queued", out_valid, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_aborted", {out_valid, busy, done, out_data}, 11'd0);
        tick();
        check("t5_no_done", done, 0);
        abort = 1'b1;
        go(8'd3);
        abort = 1'b0;
        check("t5_abort_beats_start", {busy, done}, 2'b00);
        go(8'd1);
        nib(4'h5);
        nib(4'h6);
        check("t5_new_byte", {out_valid, out_data, busy}, {1'b1, pair(4'h5, 4'h6), 1'b1});
        go(8'd0);
        check("t5_start_ignored_busy", {done, busy}, 2'b01);
        out_ready = 1'b1;
        tick();
        check("t5_done", {done, busy}, 2'b10);
        tick();

        // Asynchronous reset mid-transaction
        out_ready = 1'b0;
        go(8'd4);
        nib(4'h1);
        nib(4'h2);
        nib(4'h3);
        nib(4'h4);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_out_data", out_data, 0);
        check("t6_async_flags", {out_valid, busy, done, overflow}, 0);
        tick();
        rst = 1'b0;
        nib(4'h7);
        nib(4'h8);
        check("t6_ignored_after_rst", {out_valid, busy}, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
